// File: rtl/veririsc_pkg.sv
// Shared types for the VeriRISC sequencer: opcode and phase encodings plus the ALUOP set.
package veririsc_pkg;

  typedef enum logic [2:0] {
    HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND = 3'd3,
    XOR = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    INST_ADDR = 3'd0, INST_FETCH = 3'd1, INST_LOAD = 3'd2, IDLE = 3'd3,
    OP_ADDR   = 3'd4, OP_FETCH   = 3'd5, ALU_OP    = 3'd6, STORE = 3'd7
  } phase_t;

  // One bit per opcode value: ADD, AND, XOR and LDA read memory and load the accumulator.
  localparam logic [7:0] ALUOP_MASK = 8'b0011_1100;

  function automatic logic is_aluop(input opcode_t op);
    return ALUOP_MASK[op];
  endfunction

endpackage

// File: rtl/veririsc_ctrl_if.sv
// Sequencer bus: opcode/zero (and step when VERIRISC_CTRL_STEP_EN) in, phase and control strobes out.
interface veririsc_ctrl_if;
  import veririsc_pkg::*;

  opcode_t opcode;
  logic    zero;
`ifdef VERIRISC_CTRL_STEP_EN
  logic    step;
`endif
  phase_t  phase;
  logic    sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e;

  modport slave (
    input  opcode, zero,
`ifdef VERIRISC_CTRL_STEP_EN
    input  step,
`endif
    output phase, sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e
  );

  modport master (
    output opcode, zero,
`ifdef VERIRISC_CTRL_STEP_EN
    output step,
`endif
    input  phase, sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e
  );
endinterface

// File: rtl/veririsc_phase_gen.sv
// Wrapping 3-bit phase register; advances only when adv is set, freeze flags a held cycle.
module veririsc_phase_gen
  import veririsc_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   adv,
  output phase_t phase,
  output logic   freeze
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      phase <= INST_ADDR;
    else if (adv) phase <= phase_t'(phase + 3'd1);
  end

  assign freeze = !adv;

endmodule

// File: rtl/veririsc_ctrl.sv
// VeriRISC instruction sequencer: 8-phase cycle, halt latch and strobe decode.
// Optional single-step gating at INST_ADDR with `define VERIRISC_CTRL_STEP_EN.
module veririsc_ctrl
  import veririsc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  veririsc_ctrl_if.slave  bus
);

  phase_t phase;
  logic   halted, hlt_now, adv, freeze, aluop;

  // Halt is evaluated in OP_ADDR only; the HLT edge itself must not move the phase on.
  always_comb begin
    hlt_now = (phase == OP_ADDR) && (halted || bus.opcode == HLT);
`ifdef VERIRISC_CTRL_STEP_EN
    adv     = !hlt_now && ((phase != INST_ADDR) || bus.step);
`else
    adv     = !hlt_now;
`endif
  end

  veririsc_phase_gen u_phase (
    .clk    (clk),
    .rst    (rst),
    .adv    (adv),
    .phase  (phase),
    .freeze (freeze)
  );

  // A frozen OP_ADDR can only mean halt entry or an existing halt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              halted <= 1'b0;
    else if (phase == OP_ADDR && freeze)  halted <= 1'b1;
  end

  assign aluop     = is_aluop(bus.opcode);
  assign bus.phase = phase;

  always_comb begin
    bus.sel    = 1'b0;
    bus.rd     = 1'b0;
    bus.ld_ir  = 1'b0;
    bus.halt   = 1'b0;
    bus.inc_pc = 1'b0;
    bus.ld_ac  = 1'b0;
    bus.ld_pc  = 1'b0;
    bus.wr     = 1'b0;
    bus.data_e = 1'b0;
    case (phase)
      INST_ADDR:  bus.sel = 1'b1;
      INST_FETCH: begin
        bus.sel = 1'b1;
        bus.rd  = 1'b1;
      end
      INST_LOAD, IDLE: begin
        bus.sel   = 1'b1;
        bus.rd    = 1'b1;
        bus.ld_ir = 1'b1;
      end
      OP_ADDR: begin
        bus.inc_pc = !halted;
        bus.halt   = hlt_now;
      end
      OP_FETCH:   bus.rd = aluop;
      ALU_OP: begin
        bus.rd     = aluop;
        bus.inc_pc = (bus.opcode == SKZ) && bus.zero;
        bus.ld_pc  = (bus.opcode == JMP);
        bus.data_e = (bus.opcode == STO);
      end
      STORE: begin
        bus.rd     = aluop;
        bus.ld_ac  = aluop;
        bus.ld_pc  = (bus.opcode == JMP);
        bus.wr     = (bus.opcode == STO);
        bus.data_e = (bus.opcode == STO);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_veririsc_ctrl.sv
// Scoreboard bench for veririsc_ctrl: a phase/halt reference model predicts every cycle's outputs.
module tb_veririsc_ctrl;
  import veririsc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  veririsc_ctrl_if bus ();
  veririsc_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  // {phase[2:0], sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e}
  typedef logic [11:0] obs_t;
  obs_t exp_q[$];

  int errors = 0;
  int checks = 0;

  int m_phase  = 0;
  bit m_halted = 1'b0;

  function automatic obs_t expect_out(int ph, bit hl, int op, bit z);
    bit alu, sel, rd, ldir, hlt, inc, ldac, ldpc, wr, de;
    alu = (op == 2 || op == 3 || op == 4 || op == 5);
    {sel, rd, ldir, hlt, inc, ldac, ldpc, wr, de} = '0;
    if (ph <= 3) sel = 1;
    if (ph >= 1 && ph <= 3) rd = 1;
    if (ph == 2 || ph == 3) ldir = 1;
    if (ph == 4) begin
      hlt = hl || (op == 0);
      inc = !hl;
    end
    if (ph >= 5) rd = alu;
    if (ph == 6) inc = (op == 1) && z;
    if (ph == 7) begin
      ldac = alu;
      wr   = (op == 6);
    end
    if (ph >= 6) begin
      ldpc = (op == 7);
      de   = (op == 6);
    end
    return {3'(ph), sel, rd, ldir, hlt, inc, ldac, ldpc, wr, de};
  endfunction

  // One clock: drive at negedge, predict, then advance the model at posedge.
  task automatic cycle(input int op, input bit z, input bit r, input bit st);
    @(negedge clk);
    bus.opcode = opcode_t'(op[2:0]);
    bus.zero   = z;
`ifdef VERIRISC_CTRL_STEP_EN
    bus.step   = st;
`endif
    rst = r;
    if (r) begin
      m_phase  = 0;
      m_halted = 0;
    end
    exp_q.push_back(expect_out(m_phase, m_halted, op, z));
    @(posedge clk);
    if (r) begin
      m_phase  = 0;
      m_halted = 0;
    end else if (m_phase == 4 && (m_halted || op == 0)) begin
      m_halted = 1;
`ifdef VERIRISC_CTRL_STEP_EN
    end else if (m_phase == 0 && !st) begin
      m_phase = 0;
`endif
    end else begin
      m_phase = (m_phase + 1) % 8;
    end
  endtask

  // Monitor: every negedge the DUT presents a full output vector.
  always @(negedge clk) begin
    obs_t got, want;
    #1;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = {bus.phase, bus.sel, bus.rd, bus.ld_ir, bus.halt, bus.inc_pc,
              bus.ld_ac, bus.ld_pc, bus.wr, bus.data_e};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL outputs t=%0t got phase=%0d strobes=%b expected phase=%0d strobes=%b",
                 $time, got[11:9], got[8:0], want[11:9], want[8:0]);
      end
    end
  end

  initial begin
    bus.opcode = ADD;
    bus.zero   = 1'b0;
`ifdef VERIRISC_CTRL_STEP_EN
    bus.step   = 1'b0;
`endif
    cycle(2, 0, 1, 1);
    cycle(2, 0, 1, 1);
    // Each opcode for a full instruction, both zero values
    for (int op = 1; op < 8; op++)
      for (int z = 0; z < 2; z++)
        for (int c = 0; c < 8; c++) cycle(op, z[0], 0, 1);
    // Reset mid-ALU_OP of a store
    while (m_phase != 6) cycle(STO, 0, 0, 1);
    cycle(STO, 0, 1, 1);
    for (int c = 0; c < 4; c++) cycle(STO, 0, 0, 1);
    // Halt entry then 20 frozen clocks with a different opcode
    while (m_phase != 4) cycle(ADD, 0, 0, 1);
    cycle(HLT, 0, 0, 1);
    for (int c = 0; c < 20; c++) cycle(ADD, c[0], 0, 1);
    cycle(ADD, 0, 1, 1);
    cycle(ADD, 0, 0, 1);
`ifdef VERIRISC_CTRL_STEP_EN
    for (int c = 0; c < 5; c++) cycle(ADD, 0, 0, 0);
    cycle(ADD, 0, 0, 1);
    for (int c = 0; c < 10; c++) cycle(ADD, 0, 0, 0);
`endif
    // Random traffic with occasional resets
    for (int c = 0; c < 600; c++)
      cycle(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0));
    @(negedge clk);
    @(negedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/veririsc_ctrl.md
# veririsc_ctrl

Instruction sequencer for the VeriRISC core: an 8-phase machine that owns the instruction cycle and decodes the current opcode and accumulator-zero flag into the datapath control strobes. It sits directly upstream of the program counter. `inc_pc` drives the counter's `enable`, and `ld_pc` drives its `load`. It also drives the memory, instruction-register, accumulator and data-bus enables.

## Interface
- No parameters; widths fixed by `veririsc_pkg`.
- `clk` input 1: system clock; all state changes on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `opcode` input 3: current instruction opcode from the instruction register.
- `zero` input 1: accumulator-equals-zero flag.
- `phase` output 3: current phase, for monitors and bench.
- `sel` output 1: address mux select (1 = PC, 0 = IR operand).
- `rd` output 1: memory read.
- `ld_ir` output 1: instruction register load.
- `halt` output 1: processor halted.
- `inc_pc` output 1: PC increment (counter `enable`).
- `ld_ac` output 1: accumulator load.
- `ld_pc` output 1: PC load (counter `load`).
- `wr` output 1: memory write.
- `data_e` output 1: accumulator drives data bus.

## Operation
- **Opcodes:** HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- **ALUOP:** ADD, AND, XOR or LDA.
- **Phases:** INST_ADDR=0, INST_FETCH=1, INST_LOAD=2, IDLE=3, OP_ADDR=4, OP_FETCH=5, ALU_OP=6, STORE=7.
- **Sequence:** phase advances by one per clock; STORE wraps to INST_ADDR (7 → 0).
- **Strobes:** decoded combinationally from registered `phase`, `opcode`, `zero` and the halted flag. Any strobe not listed for a phase is 0.
  - INST_ADDR: sel=1.
  - INST_FETCH: sel=1, rd=1.
  - INST_LOAD and IDLE: sel=1, rd=1, ld_ir=1.
  - OP_ADDR: inc_pc = !halted; halt = halted | (opcode==HLT).
  - OP_FETCH: rd=ALUOP.
  - ALU_OP: rd=ALUOP, inc_pc=(SKZ & zero), ld_pc=JMP, data_e=STO.
  - STORE: rd=ALUOP, ld_ac=ALUOP, ld_pc=JMP, wr=STO, data_e=STO.
- **Halt entry:** HLT in OP_ADDR sets the `halted` register at that edge. The PC still increments once on that edge.
- **While halted:**
  - phase freezes at OP_ADDR;
  - halt=1, inc_pc=0, all other strobes 0;
  - `opcode` and `zero` are ignored.
  - Only `rst` leaves the halted state.
- **Reset:** phase=INST_ADDR and halted=0. Outputs during reset: sel=1, all others 0.
- **Reset mid-cycle:** `rst` asserted in any phase, including mid-STORE, returns immediately to the reset state. No partial strobe completes after reset assertion.

## Timing
- Strobes are valid from just after the clock edge that enters a phase until the next edge. Downstream registers sample them at the phase's closing edge.
- Counter interaction:
  - inc_pc in OP_ADDR advances the PC at the OP_ADDR→OP_FETCH edge.
  - SKZ with zero=1 adds a second increment at the ALU_OP→STORE edge.
  - JMP asserts ld_pc in both ALU_OP and STORE; the PC is loaded at both edges with the same value.
- wr is asserted for STORE only, one cycle; data_e brackets it (ALU_OP and STORE).
- One instruction takes 8 clocks. Latency from reset release to the first ld_ir is 2 edges.

## Configuration
- `VERIRISC_CTRL_STEP_EN` defined:
  - adds input `step` (1 bit);
  - phase holds at INST_ADDR until a clock edge samples step=1, then advances normally;
  - INST_ADDR strobes (sel=1 only) are repeated harmlessly while holding;
  - step is ignored in all other phases and while halted.
- Undefined: no `step` port; free-running sequence.

## Structure
- `veririsc_pkg` holds:
  - `opcode_t` enum (3-bit, values above);
  - `phase_t` enum (3-bit, values above);
  - localparams for the ALUOP set.
- One sub-module, `veririsc_phase_gen`: 3-bit wrapping phase register with async reset, advance-enable input (driven by !halted, and by the step gating when enabled) and freeze output.
- Decode and the halted register live in `veririsc_ctrl`.

## Test plan
- **Reset:** assert rst mid-ALU_OP with opcode=STO → phase=0, sel=1, wr=0, data_e=0 immediately; after release, phase 0→1→2 on successive edges; ld_ir=1 at phase 2.
- **ADD cycle:** opcode=ADD, zero=0 over 8 clocks → rd=1 in phases 1,2,3,5,6,7; inc_pc=1 only in phase 4; ld_ac=1 only in phase 7; wr=0 throughout.
- **STO and JMP:** opcode=STO → data_e=1 in phases 6–7, wr=1 in phase 7 only. opcode=JMP → ld_pc=1 in phases 6 and 7; inc_pc=1 only in phase 4.
- **SKZ:** opcode=SKZ, zero=1 → inc_pc=1 in phases 4 and 6; with zero=0 → inc_pc=1 in phase 4 only.
- **HLT:** opcode=HLT at phase 4 → halt=1 and inc_pc=1 that cycle. For the next 20 clocks: phase stays 4, halt=1, inc_pc=0, even with opcode changed to ADD. rst then clears halt to 0.
- **Step (`VERIRISC_CTRL_STEP_EN`):** step=0 for 5 clocks → phase stays 0; single-cycle step=1 → phase sequences 1..7 then holds at 0 again.
